div_seq_ctrl: RTL and testbench

- Sequencing controller for the non-restoring divider datapath: A (remainder, N+1 bits), Q (quotient/dividend, N bits), D (divisor, N+1 bits) and the registered add/subtract unit.
- Per iteration it issues load, shift, add/sub and write-back strobes, counts iterations, applies the final remainder restore, and runs a start/ready/done handshake toward the issuing logic.
- Datapath registers and the add/sub unit live outside this block.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_iter_cnt.sv | 19 +
 rtl/div_seq_ctrl.sv | 82 ++++++++
 tb/tb_div_seq_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter-width helper for the divider sequencer.
package div_pkg;
    localparam int N_DEF = 6;
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_SHIFT     = 3'd2,
        S_OP        = 3'd3,
        S_WRITE     = 3'd4,
        S_FIX_OP    = 3'd5,
        S_FIX_WRITE = 3'd6,
        S_DONE      = 3'd7
    } state_t;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/div_iter_cnt.sv
// div_iter_cnt: loadable iteration down-counter with a last-iteration (cnt==1) flag.
module div_iter_cnt #(
    parameter int N     = 6,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (load) cnt <= CNT_W'(N);
        else if (dec && cnt != '0) cnt <= cnt - CNT_W'(1);
    end
    assign last = cnt == CNT_W'(1);
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: non-restoring divider sequencer (strobes, iteration count, remainder fix, handshake).
// Optional divide-by-zero early exit is enabled with DIV_ZERO_CHK_EN.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = cnt_width(N)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic a_msb,
    input  logic s_msb,
`ifdef DIV_ZERO_CHK_EN
    input  logic d_zero,
    output logic err,
`endif
    output logic ld_aqd,
    output logic shl_aq,
    output logic add,
    output logic sub,
    output logic ld_a,
    output logic wr_q0,
    output logic q0,
    output logic ready,
    output logic busy,
    output logic done
);
    state_t state, nxt;
    logic   last;
    logic   zero_div;

`ifdef DIV_ZERO_CHK_EN
    assign zero_div = d_zero;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else if (state == S_LOAD) err <= d_zero;
    end
`else
    assign zero_div = 1'b0;
`endif

    div_iter_cnt #(.N(N), .CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (state == S_LOAD),
        .dec  (state == S_WRITE),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:      nxt = start ? S_LOAD : S_IDLE;
            S_LOAD:      nxt = zero_div ? S_DONE : S_SHIFT;
            S_SHIFT:     nxt = S_OP;
            S_OP:        nxt = S_WRITE;
            S_WRITE:     nxt = !last ? S_SHIFT : (s_msb ? S_FIX_OP : S_DONE);
            S_FIX_OP:    nxt = S_FIX_WRITE;
            S_FIX_WRITE: nxt = S_DONE;
            S_DONE:      nxt = S_IDLE;
            default:     nxt = S_IDLE;
        endcase
    end

    // s_msb is the registered add/sub result, valid only in the cycle after OP/FIX_OP
    assign ld_aqd = state == S_LOAD;
    assign shl_aq = state == S_SHIFT;
    assign sub    = state == S_OP && !a_msb;
    assign add    = (state == S_OP && a_msb) || state == S_FIX_OP;
    assign ld_a   = state == S_WRITE || state == S_FIX_WRITE;
    assign wr_q0  = state == S_WRITE;
    assign q0     = wr_q0 && !s_msb;
    assign ready  = state == S_IDLE;
    assign busy   = state != S_IDLE && state != S_DONE;
    assign done   = state == S_DONE;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed bench pairing the sequencer with a behavioural N=6 divider datapath.
module tb_div_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic a_msb, s_msb;
    logic ld_aqd, shl_aq, add, sub, ld_a, wr_q0, q0, ready, busy, done;
`ifdef DIV_ZERO_CHK_EN
    logic d_zero, err;
`endif
    logic [5:0] dividend = '0, divisor = '0, q_r = '0;
    logic [6:0] a_r = '0, d_r = '0, s_r = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_seq_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_msb  (a_msb),
        .s_msb  (s_msb),
`ifdef DIV_ZERO_CHK_EN
        .d_zero (d_zero),
        .err    (err),
`endif
        .ld_aqd (ld_aqd),
        .shl_aq (shl_aq),
        .add    (add),
        .sub    (sub),
        .ld_a   (ld_a),
        .wr_q0  (wr_q0),
        .q0     (q0),
        .ready  (ready),
        .busy   (busy),
        .done   (done)
    );

`ifdef DIV_ZERO_CHK_EN
    assign d_zero = divisor == 6'd0;
`endif
    assign a_msb = a_r[6];
    assign s_msb = s_r[6];

    // behavioural datapath: A, Q, D registers and a registered add/sub unit
    always @(posedge clk) begin
        if (ld_aqd) begin
            a_r <= '0;
            q_r <= dividend;
            d_r <= {1'b0, divisor};
        end
        if (shl_aq) {a_r, q_r} <= {a_r[5:0], q_r, 1'b0};
        if (add) s_r <= a_r + d_r;
        if (sub) s_r <= a_r - d_r;
        if (ld_a) a_r <= s_r;
        if (wr_q0) q_r[0] <= q0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: single start pulse, 1: start held through run, 2: extra start pulse mid-run
    task automatic run(input logic [5:0] dvd, input logic [5:0] dvs, input int mode,
                       input int exp_q, input int exp_r, input int exp_edge, input int exp_fix);
        int n, wq, fx, ops, nd;
        logic both, first_add;
        n = 0; wq = 0; fx = 0; ops = 0; nd = 0; both = 1'b0; first_add = 1'b0;
        dividend = dvd;
        divisor = dvs;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = mode == 1;
        while (!done && n < 200) begin
            wq += int'(wr_q0);
            fx += int'(ld_a && !wr_q0);
            both = both | (add && sub);
            if (add || sub) begin
                if (ops == 0) first_add = add;
                ops++;
            end
            if (mode == 2) start = n == 7;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_edge", n, exp_edge);
        chk("wr_q0_count", wq, 6);
        chk("fix_count", fx, exp_fix);
        chk("add_sub_both", 32'(both), 0);
        chk("first_op_add", 32'(first_add), 0);
        chk("quotient", 32'(q_r), exp_q);
        chk("remainder", 32'(a_r), exp_r);
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("ready_after_done", 32'(ready), 1);
        repeat (25) begin
            @(posedge clk);
            @(negedge clk);
            nd += int'(done);
        end
        chk("no_extra_done", nd, 0);
    endtask

    initial begin
        int n, ops, nd;
        repeat (2) @(negedge clk);
        chk("rst_strobes", 32'({ld_aqd, shl_aq, add, sub, ld_a, wr_q0, q0, busy, done}), 0);
        chk("rst_ready", 32'(ready), 1);
        rst = 1'b1;
        @(negedge clk);

        run(6'd13, 6'd4, 0, 3, 1, 19, 0);
        run(6'd0, 6'd5, 0, 0, 0, 21, 1);
        run(6'd63, 6'd1, 0, 63, 0, 19, 0);
        run(6'd13, 6'd4, 1, 3, 1, 19, 0);
        run(6'd63, 6'd1, 2, 63, 0, 19, 0);
        run(6'd20, 6'd3, 0, 6, 2, 21, 1);

        // asynchronous reset during the third OP
        dividend = 6'd13;
        divisor = 6'd4;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0; ops = 0; nd = 0;
        while (n < 100) begin
            if (add || sub) ops++;
            if (ops == 3) break;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("third_op_reached", ops, 3);
        #2 rst = 1'b0;
        #1;
        chk("abort_strobes", 32'({ld_aqd, shl_aq, add, sub, ld_a, wr_q0, q0, busy, done}), 0);
        chk("abort_ready", 32'(ready), 1);
        repeat (3) begin
            @(negedge clk);
            nd += int'(done);
        end
        chk("abort_no_done", nd, 0);
        rst = 1'b1;
        @(negedge clk);
        run(6'd13, 6'd4, 0, 3, 1, 19, 0);

`ifdef DIV_ZERO_CHK_EN
        dividend = 6'd9;
        divisor = 6'd0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("zero_done_edge", n, 1);
        chk("zero_err", 32'(err), 1);
        repeat (4) @(negedge clk);
        chk("zero_err_held", 32'(err), 1);
        run(6'd9, 6'd3, 0, 3, 0, 19, 0);
        chk("err_cleared", 32'(err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
